// File: rtl/barrett_pipe_if.sv
// barrett_pipe_if: valid/ready sample bus into and out of the Barrett reducer (out_ovf only with BARRETT_OVF_EN)
interface barrett_pipe_if #(
    parameter int DATA_W = 24,
    parameter int OUT_W  = 16,
    parameter int TAG_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [TAG_W-1:0]  out_tag;
`ifdef BARRETT_OVF_EN
    logic              out_ovf;
`endif

    modport master (
        output in_valid, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
`ifdef BARRETT_OVF_EN
        , input out_ovf
`endif
    );

    modport slave (
        input  in_valid, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
`ifdef BARRETT_OVF_EN
        , output out_ovf
`endif
    );
endinterface

// File: rtl/barrett_pipe.sv
// barrett_pipe: 4-stage valid/ready Barrett reducer c -> c mod Q with tag sideband; BARRETT_OVF_EN adds out_ovf (c >= Q*Q)
module barrett_pipe #(
    parameter int DATA_W = 24,
    parameter int OUT_W  = 16,
    parameter int Q      = 3329,
    parameter int K      = 26,
    parameter int V      = 20159,
    parameter int TAG_W  = 8
) (
    input logic           clk,
    input logic           rst,
    barrett_pipe_if.slave bus
);
    localparam int P_W = DATA_W + 16;
    localparam int R_W = DATA_W + 2;
    localparam int T_W = P_W - K;
    localparam logic [P_W-1:0] VP  = P_W'(V);
    localparam logic [P_W-1:0] RND = P_W'(1) << (K - 1);
    localparam logic [R_W-1:0] QU  = R_W'(Q);
`ifdef BARRETT_OVF_EN
    localparam logic [DATA_W-1:0] QQ = DATA_W'(Q * Q);
`endif

    logic                    adv;
    logic [T_W-1:0]          t;
    logic signed [R_W-1:0]   fix;
    logic                    v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
    logic [TAG_W-1:0]        tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d, tag4_q, tag4_d;
    logic [DATA_W-1:0]       c1_q, c1_d, c2_q, c2_d;
    logic [P_W-1:0]          p1_q, p1_d;
    logic [R_W-1:0]          m2_q, m2_d;
    logic signed [R_W-1:0]   r3_q, r3_d;
    logic [OUT_W-1:0]        d4_q, d4_d;
`ifdef BARRETT_OVF_EN
    logic                    o1_q, o1_d, o2_q, o2_d, o3_q, o3_d, o4_q, o4_d;
`endif

    // Next-state of every stage: multiply, quotient estimate, subtract, single correction
    always_comb begin
        adv    = !v4_q || bus.out_ready;
        v1_d   = bus.in_valid;
        tag1_d = bus.in_tag;
        c1_d   = bus.in_data;
        p1_d   = P_W'(bus.in_data) * VP;
        t      = T_W'((p1_q + RND) >> K);
        v2_d   = v1_q;
        tag2_d = tag1_q;
        c2_d   = c1_q;
        m2_d   = R_W'(t) * QU;
        v3_d   = v2_q;
        tag3_d = tag2_q;
        r3_d   = $signed({2'b00, c2_q}) - $signed(m2_q);
        fix    = r3_q[R_W-1] ? r3_q + $signed(QU) : (r3_q >= $signed(QU) ? r3_q - $signed(QU) : r3_q);
        v4_d   = v3_q;
        tag4_d = tag3_q;
        d4_d   = fix[OUT_W-1:0];
`ifdef BARRETT_OVF_EN
        o1_d   = bus.in_data >= QQ;
        o2_d   = o1_q;
        o3_d   = o2_q;
        o4_d   = o3_q;
`endif
    end

    // Whole pipe shifts together only when the output slot is free or being drained
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0; v4_q <= 1'b0;
            tag1_q <= '0; tag2_q <= '0; tag3_q <= '0; tag4_q <= '0;
            c1_q <= '0; c2_q <= '0; p1_q <= '0; m2_q <= '0; r3_q <= '0; d4_q <= '0;
`ifdef BARRETT_OVF_EN
            o1_q <= 1'b0; o2_q <= 1'b0; o3_q <= 1'b0; o4_q <= 1'b0;
`endif
        end else if (adv) begin
            v1_q <= v1_d; v2_q <= v2_d; v3_q <= v3_d; v4_q <= v4_d;
            tag1_q <= tag1_d; tag2_q <= tag2_d; tag3_q <= tag3_d; tag4_q <= tag4_d;
            c1_q <= c1_d; c2_q <= c2_d; p1_q <= p1_d; m2_q <= m2_d; r3_q <= r3_d; d4_q <= d4_d;
`ifdef BARRETT_OVF_EN
            o1_q <= o1_d; o2_q <= o2_d; o3_q <= o3_d; o4_q <= o4_d;
`endif
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = v4_q;
    assign bus.out_data  = d4_q;
    assign bus.out_tag   = tag4_q;
`ifdef BARRETT_OVF_EN
    assign bus.out_ovf   = o4_q;
`endif
endmodule
